nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request a 16-bit add; sampled only in IDLE.
REQ-004 SHALL have port: op_a  input  16  operand A; captured on an accepted start.
REQ-005 SHALL have port: op_b  input  16  operand B; captured on an accepted start.
REQ-006 SHALL have port: cin  input  1  carry-in; captured on an accepted start.
REQ-007 SHALL have port: busy  output  1  high while nibbles are being processed.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when result is valid.
REQ-009 SHALL have port: result  output  16  registered sum; held between operations.
REQ-010 SHALL have port: cout  output  1  carry out of bit 15; registered with result.
REQ-011 SHALL have port: ovf  output  1  signed two's-complement overflow; registered with result.

Function
REQ-012 SHALL compute the 16-bit sum through one shared 4-bit adder (4-bit A + 4-bit B + carry -> 4-bit sum + carry), one nibble per cycle, least significant nibble first.
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, capture op_a, op_b and cin into internal registers, clear the 2-bit nibble counter to 0, and go to RUN.
REQ-015 SHALL, in each RUN cycle, add nibble[cnt] of A and B with the carry register, write the 4-bit sum into accumulator nibble[cnt], store the carry out in the carry register, and increment cnt.
REQ-016 SHALL go from RUN to DONE on the cycle cnt==3 is processed; cnt SHALL wrap 3->0.
REQ-017 SHALL, on the transition to DONE, load result from the accumulator, cout from the final carry, and ovf = (A[15]==B'[15]) & (sum[15]!=A[15]), where B' is the effective B operand.
REQ-018 SHALL hold done=1 for exactly the one DONE cycle and then return to IDLE unconditionally.
REQ-019 SHALL assert busy exactly while in RUN.
REQ-020 SHALL have a fixed latency: start accepted at edge N gives busy high for cycles N+1..N+4 and done high in cycle N+5.
REQ-021 SHALL ignore start while in RUN or DONE; captured operands SHALL NOT change.
REQ-022 SHALL accept start in the first IDLE cycle after DONE, so back-to-back operations have a 6-cycle period.
REQ-023 SHALL keep result, cout and ovf unchanged from one DONE until the next DONE; they SHALL NOT show partial sums.

Reset
REQ-024 SHALL, when reset=1 at a clock edge, set state=IDLE, cnt=0, carry register=0, accumulator=0, result=16'h0000, cout=0, ovf=0, busy=0 and done=0.
REQ-025 SHALL give reset priority over start and abort an operation in progress; no done pulse SHALL follow an aborted operation.
REQ-026 SHALL hold all outputs at their reset values for as long as reset stays high.

Configuration
REQ-027 SHALL, when macro NIBBLE_ADD_SEQ_SUB_EN is defined, add port sub (input, 1, captured on an accepted start).
REQ-028 With NIBBLE_ADD_SEQ_SUB_EN defined and sub=1: B' SHALL be ~op_b, the initial carry SHALL be 1 and cin SHALL be ignored, so result = A - B and cout = 1 means no borrow.
REQ-029 With NIBBLE_ADD_SEQ_SUB_EN defined and sub=0, and always when the macro is undefined: B' SHALL be op_b and the initial carry SHALL be cin.
REQ-030 When NIBBLE_ADD_SEQ_SUB_EN is undefined, the sub port and its logic SHALL be absent.

Verification
REQ-031 Basic add: op_a=0x1234, op_b=0x4321, cin=0, start at edge N -> busy high for N+1..N+4; done at N+5 with result=0x5555, cout=0, ovf=0.
REQ-032 Full carry propagation: op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1, ovf=0.
REQ-033 Signed overflow: op_a=0x7FFF, op_b=0x0001, cin=0 -> result=0x8000, cout=0, ovf=1. With cin=1, 0x0000+0x0000 -> result=0x0001.
REQ-034 Start while busy: start 0x0001+0x0001, then pulse start with 0xFFFF/0xFFFF at N+2 -> done only at N+5 with result=0x0002; the second request SHALL NOT be taken.
REQ-035 Reset mid-run: reset high at N+2 -> next cycle busy=0, result=0x0000; done stays 0 through N+8. A fresh start afterwards completes normally.
REQ-036 Subtract (NIBBLE_ADD_SEQ_SUB_EN defined): sub=1, op_a=0x0005, op_b=0x0007 -> result=0xFFFE, cout=0, ovf=0. With 0x0007-0x0005 -> result=0x0002, cout=1.

Source files
------------

// File: rtl/nibble_add_seq_if.sv
// nibble_add_seq_if: operand/result bundle for the nibble-serial adder (sub signal present with NIBBLE_ADD_SEQ_SUB_EN)
interface nibble_add_seq_if;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  modport master (
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    output sub,
`endif
    output start, op_a, op_b, cin,
    input  busy, done, result, cout, ovf
  );
  modport slave (
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  sub,
`endif
    input  start, op_a, op_b, cin,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: 16-bit add through one shared 4-bit adder, one nibble per cycle; NIBBLE_ADD_SEQ_SUB_EN adds subtract
module nibble_add_seq (
  input logic            clk,
  input logic            reset,
  nibble_add_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [15:0] a_q, b_q, acc_q, result_q;
  logic [1:0]  cnt_q;
  logic        carry_q, cout_q, ovf_q, busy_q, done_q;
  logic [4:0]  nib_sum_d;
  logic [15:0] b_eff_d;
  logic        cin_eff_d;
  // shared 4-bit adder on the current nibble, plus effective B operand and initial carry
  always_comb begin
    nib_sum_d = {1'b0, a_q[{cnt_q, 2'b00} +: 4]} + {1'b0, b_q[{cnt_q, 2'b00} +: 4]} + {4'b0, carry_q};
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    b_eff_d   = bus.sub ? ~bus.op_b : bus.op_b;
    cin_eff_d = bus.sub | bus.cin;
`else
    b_eff_d   = bus.op_b;
    cin_eff_d = bus.cin;
`endif
  end
  // control FSM with datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_q     <= bus.op_a;
          b_q     <= b_eff_d;
          carry_q <= cin_eff_d;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          acc_q[{cnt_q, 2'b00} +: 4] <= nib_sum_d[3:0];
          carry_q <= nib_sum_d[4];
          cnt_q   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            result_q <= {nib_sum_d[3:0], acc_q[11:0]};
            cout_q   <= nib_sum_d[4];
            ovf_q    <= (a_q[15] == b_q[15]) & (nib_sum_d[3] != a_q[15]);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: random and directed checks of nibble_add_seq against an arithmetic reference model
module tb_nibble_add_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  nibble_add_seq_if bus ();
  nibble_add_seq dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    int sv, uv;
    logic [31:0] u;
    if (s) begin
      sv = $signed(a) - $signed(b);
      uv = int'(a) - int'(b);
    end else begin
      sv = $signed(a) + $signed(b) + int'(c);
      uv = int'(a) + int'(b) + int'(c);
    end
    u = uv;
    return {(sv > 32767 || sv < -32768), s ? (uv >= 0) : (uv > 65535), u[15:0]};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    bus.sub   = s;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    logic [17:0] e;
    e = model(a, b, c, s);
    drive(a, b, c, s);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
      if (i < 3) tick();
    end
    tick();
    chk({tag, "_done"}, 32'({bus.busy, bus.done}), 32'b01);
    chk({tag, "_res"}, 32'({bus.ovf, bus.cout, bus.result}), 32'(e));
    tick();
    chk({tag, "_after"}, 32'({bus.busy, bus.done}), 32'b00);
    chk({tag, "_held"}, 32'({bus.ovf, bus.cout, bus.result}), 32'(e));
  endtask

  initial begin
    logic s;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) tick();
    bus.start = 1'b1;
    bus.op_a  = 16'h1111;
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out", 32'({bus.ovf, bus.cout, bus.result}), 32'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    run_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("cin", 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op("negovf", 16'h8000, 16'hFFFF, 1'b0, 1'b0);
    // a second start while running must be ignored
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    chk("ign_nodone", 32'(bus.done), 32'd0);
    tick();
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_res", 32'({bus.ovf, bus.cout, bus.result}), 32'h0002);
    tick();
    chk("ign_after", 32'({bus.busy, bus.done}), 32'd0);
    // reset in the middle of an operation
    drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_res", 32'({bus.ovf, bus.cout, bus.result}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone", 32'(bus.done), 32'd0);
      tick();
    end
    run_op("fresh", 16'hABCD, 16'h1234, 1'b1, 1'b0);
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
`endif
    for (int k = 0; k < 40; k++) begin
      s = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      s = 1'($urandom_range(0, 1));
`endif
      run_op("rnd", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), s);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
